rmatrix_sequencer: RTL and testbench
====================================

Name: rmatrix_sequencer

Overview:
- Sequences the shared rotation-matrix datapath (Rmatrix). Arbitrates angle-pair requests from two sources: the balance controller (ctrl) and the calibration/manual path (cal).
- For each granted request it clamps the angles, pulses the datapath start, waits for its result and captures the nine 16-bit elements.
- It presents the captured matrix to the servo-kinematics stage with a one-cycle valid pulse and a source tag. A watchdog recovers the sequencer if the datapath never answers.

Parameters:
MAX_ANGLE, 13'sd256, clamp magnitude for Rx/Ry (signed 3.10 in units of pi; 256 = 45 deg)
TIMEOUT, 64, max clock cycles spent in WAIT before abort
TW, 7, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising clock edge resets the block
ctrl_valid  in  1  controller request valid
ctrl_rx  in  13  controller X angle, signed 3.10 (pi units)
ctrl_ry  in  13  controller Y angle, signed 3.10
ctrl_ready  out  1  controller request accepted this cycle
cal_valid  in  1  calibration request valid
cal_rx  in  13  calibration X angle
cal_ry  in  13  calibration Y angle
cal_ready  out  1  calibration request accepted this cycle
rm_valid_in  out  1  start pulse to Rmatrix validIn
rm_rx  out  13  Rx to Rmatrix
rm_ry  out  13  Ry to Rmatrix
rm_valid_out  in  1  Rmatrix result valid
rm_r  in  144  Rmatrix R11..R33, with R11 in [15:0] and R33 in [143:128]
m_r  out  144  captured matrix, same packing
m_valid  out  1  one-cycle pulse: m_r updated
m_src  out  1  source of the current m_r (0=ctrl, 1=cal)
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state=IDLE; rm_valid_in, m_valid, err_timeout, ctrl_ready and cal_ready all 0; rm_rx, rm_ry, m_r and m_src all 0; last_grant=1 (cal), so ctrl wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant is combinational. Only ctrl valid -> ctrl. Only cal valid -> cal. Both valid -> the source that is not last_grant (round-robin).
  - The granted source's ready is 1 for that single cycle. Transfer happens when valid&&ready at the edge.
  - On transfer: latch clamped angles into rm_rx/rm_ry, update last_grant and the pending source tag, go to ISSUE.
  - ready is never 1 outside IDLE.
- Clamp: signed compare. v > MAX_ANGLE -> MAX_ANGLE. v < -MAX_ANGLE -> -MAX_ANGLE. Otherwise pass through unchanged.
- ISSUE: rm_valid_in=1 for exactly this cycle. Clear the watchdog counter, go to WAIT.
- WAIT:
  - rm_rx and rm_ry are held stable.
  - If rm_valid_out=1: capture rm_r into m_r, set m_src to the pending tag, go to DONE.
  - Else, when the counter reaches TIMEOUT-1: pulse err_timeout next cycle, return to IDLE, leave m_r/m_src unchanged.
  - Otherwise increment the counter.
- DONE: m_valid=1 for this cycle only, then IDLE. A new request may be accepted in the cycle after DONE.
- Latency: request accepted at edge E0 -> rm_valid_in high during cycle E0+1. If rm_valid_out is sampled at edge Ek, m_valid is high during cycle Ek+1.
- rm_valid_out in IDLE, ISSUE or DONE is ignored (no capture, no error).
- rm_valid_out at the same edge as the timeout -> capture wins; no err_timeout.
- Back-to-back: with both sources continuously valid, grants alternate ctrl, cal, ctrl, ...
- Reset mid-operation: the in-flight result is discarded and all outputs return to reset values. A stale rm_valid_out arriving after reset is ignored.
- One request in flight at a time; requesters are held off via ready.

Test Plan:
- Single ctrl request rx=-170 (13'h1F56), ry=+170 (13'h0AA), with a model datapath answering 3 cycles after start -> rm_valid_in pulses exactly once with rm_rx=-170 and rm_ry=170; m_valid pulses once, 1 cycle after rm_valid_out; m_r equals model output; m_src=0.
- Clamp: cal request rx=+300, ry=-300 with MAX_ANGLE=256 -> rm_rx=256, rm_ry=-256; m_src=1.
- Arbitration: ctrl_valid and cal_valid held high for 4 transactions -> grant order ctrl, cal, ctrl, cal; ready never high outside IDLE; the non-granted requester stalls with its inputs held.
- Timeout: model never asserts rm_valid_out -> err_timeout pulses exactly TIMEOUT+1 cycles after rm_valid_in; m_valid stays 0; m_r is unchanged; the next request is served normally.
- Timeout boundary: rm_valid_out on the final WAIT cycle -> capture occurs, err_timeout=0.
- Reset: reset=0 for one edge during WAIT, then the model raises rm_valid_out -> no m_valid, m_r=0, state IDLE; ready is asserted again on the next request.

Source files
------------

// File: rtl/rmatrix_sequencer.sv
// Rotation-matrix datapath sequencer: arbitrates ctrl/cal angle requests,
// clamps the angles, starts the shared Rmatrix datapath, captures its result
// and presents it downstream with a source tag. A watchdog aborts a request
// that never receives a datapath answer.
module rmatrix_sequencer #(
  parameter logic signed [12:0] MAX_ANGLE = 13'sd256,
  parameter int unsigned        TIMEOUT   = 64,
  parameter int unsigned        TW        = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ctrl_valid,
  input  logic [12:0]   ctrl_rx,
  input  logic [12:0]   ctrl_ry,
  output logic          ctrl_ready,
  input  logic          cal_valid,
  input  logic [12:0]   cal_rx,
  input  logic [12:0]   cal_ry,
  output logic          cal_ready,
  output logic          rm_valid_in,
  output logic [12:0]   rm_rx,
  output logic [12:0]   rm_ry,
  input  logic          rm_valid_out,
  input  logic [143:0]  rm_r,
  output logic [143:0]  m_r,
  output logic          m_valid,
  output logic          m_src,
  output logic          err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          last_grant;
  logic          pend_src;
  logic          grant_cal;
  logic [TW-1:0] wd_cnt;
  logic          wd_expired;

  assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));

  // Saturate a signed 3.10 angle to +/-MAX_ANGLE.
  function automatic logic [12:0] clamp(input logic [12:0] v);
    logic signed [12:0] s;
    s = $signed(v);
    if (s > MAX_ANGLE)
      return $unsigned(MAX_ANGLE);
    else if (s < -MAX_ANGLE)
      return $unsigned(-MAX_ANGLE);
    else
      return v;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state, round-robin grant and per-state strobes.
  always_comb begin
    state_nx    = state;
    grant_cal   = 1'b0;
    ctrl_ready  = 1'b0;
    cal_ready   = 1'b0;
    rm_valid_in = 1'b0;
    m_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_valid && cal_valid)
          grant_cal = ~last_grant;
        else
          grant_cal = cal_valid;
        ctrl_ready = ctrl_valid && !grant_cal;
        cal_ready  = cal_valid && grant_cal;
        if (ctrl_ready || cal_ready)
          state_nx = ISSUE;
      end
      ISSUE: begin
        rm_valid_in = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        // A result on the last watchdog cycle still wins over the abort.
        if (rm_valid_out)
          state_nx = DONE;
        else if (wd_expired)
          state_nx = IDLE;
      end
      DONE: begin
        m_valid  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Angle latch, grant history, watchdog, result capture and abort pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rm_rx       <= '0;
      rm_ry       <= '0;
      m_r         <= '0;
      m_src       <= 1'b0;
      last_grant  <= 1'b1;
      pend_src    <= 1'b0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_ready || cal_ready) begin
            rm_rx      <= clamp(grant_cal ? cal_rx : ctrl_rx);
            rm_ry      <= clamp(grant_cal ? cal_ry : ctrl_ry);
            last_grant <= grant_cal;
            pend_src   <= grant_cal;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          if (rm_valid_out) begin
            m_r   <= rm_r;
            m_src <= pend_src;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rmatrix_sequencer.sv
// Directed + randomized bench for rmatrix_sequencer with a transaction-level
// reference (round-robin grant history, integer clamp, expected matrix/tag).
module tb_rmatrix_sequencer;

  localparam int TIMEOUT = 64;
  localparam int MAXA    = 256;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_valid, cal_valid;
  logic [12:0]   ctrl_rx, ctrl_ry, cal_rx, cal_ry;
  logic          ctrl_ready, cal_ready;
  logic          rm_valid_in, rm_valid_out;
  logic [12:0]   rm_rx, rm_ry;
  logic [143:0]  rm_r, m_r;
  logic          m_valid, m_src, err_timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  // Reference model state
  bit           m_last;
  logic [143:0] exp_r;
  bit           exp_src;

  rmatrix_sequencer #(
    .MAX_ANGLE(13'sd256),
    .TIMEOUT  (TIMEOUT),
    .TW       (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ctrl_valid  (ctrl_valid),
    .ctrl_rx     (ctrl_rx),
    .ctrl_ry     (ctrl_ry),
    .ctrl_ready  (ctrl_ready),
    .cal_valid   (cal_valid),
    .cal_rx      (cal_rx),
    .cal_ry      (cal_ry),
    .cal_ready   (cal_ready),
    .rm_valid_in (rm_valid_in),
    .rm_rx       (rm_rx),
    .rm_ry       (rm_ry),
    .rm_valid_out(rm_valid_out),
    .rm_r        (rm_r),
    .m_r         (m_r),
    .m_valid     (m_valid),
    .m_src       (m_src),
    .err_timeout (err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ref_clamp(input logic [12:0] v);
    int s;
    s = $signed(v);
    if (s > MAXA) s = MAXA;
    else if (s < -MAXA) s = -MAXA;
    return s[12:0];
  endfunction

  function automatic logic [143:0] rand_mat();
    return {16'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_idle_strobes(input string tag);
    chk({tag, "_ctrl_ready"}, 144'(ctrl_ready), 144'(1'b0));
    chk({tag, "_cal_ready"},  144'(cal_ready),  144'(1'b0));
    chk({tag, "_m_valid"},    144'(m_valid),    144'(1'b0));
  endtask

  // One request from IDLE. lat<0: datapath never answers (watchdog path).
  // lat>=0: number of silent WAIT cycles before the single-cycle answer.
  task automatic run_txn(input bit cv, input bit kv,
                         input logic [12:0] crx, input logic [12:0] cry,
                         input logic [12:0] krx, input logic [12:0] kry,
                         input int lat, input bit hold);
    bit           g;
    logic [12:0]  erx, ery;
    logic [143:0] rr;
    g = (cv && kv) ? !m_last : (kv && !cv);
    ctrl_valid = cv; cal_valid = kv;
    ctrl_rx = crx; ctrl_ry = cry; cal_rx = krx; cal_ry = kry;
    #1;
    chk("grant_ctrl_ready", 144'(ctrl_ready), 144'(cv && !g));
    chk("grant_cal_ready",  144'(cal_ready),  144'(kv && g));
    step();
    m_last = g;
    erx = ref_clamp(g ? krx : crx);
    ery = ref_clamp(g ? kry : cry);
    if (!hold) begin ctrl_valid = 1'b0; cal_valid = 1'b0; end
    chk("issue_rm_valid_in", 144'(rm_valid_in), 144'(1'b1));
    chk("issue_rm_rx", 144'(rm_rx), 144'(erx));
    chk("issue_rm_ry", 144'(rm_ry), 144'(ery));
    chk_idle_strobes("issue");
    step();
    if (lat < 0) begin
      for (int i = 1; i <= TIMEOUT + 1; i++) begin
        chk("wd_err_timeout", 144'(err_timeout), 144'(i == TIMEOUT + 1));
        chk("wd_m_valid", 144'(m_valid), 144'(1'b0));
        chk("wd_rm_valid_in", 144'(rm_valid_in), 144'(1'b0));
        if (i <= TIMEOUT) begin
          chk("wd_ctrl_ready", 144'(ctrl_ready), 144'(1'b0));
          chk("wd_rm_rx_held", 144'(rm_rx), 144'(erx));
        end
        if (i <= TIMEOUT) step();
      end
      chk("wd_m_r_unchanged", m_r, exp_r);
      chk("wd_m_src_unchanged", 144'(m_src), 144'(exp_src));
      step();
      chk("wd_err_single", 144'(err_timeout), 144'(1'b0));
    end else begin
      for (int i = 0; i < lat; i++) begin
        chk_idle_strobes("wait");
        chk("wait_rm_valid_in", 144'(rm_valid_in), 144'(1'b0));
        chk("wait_rm_ry_held", 144'(rm_ry), 144'(ery));
        step();
      end
      rr = rand_mat();
      rm_valid_out = 1'b1; rm_r = rr;
      step();
      rm_valid_out = 1'b0; rm_r = rand_mat();
      exp_r = rr; exp_src = g;
      chk("done_m_valid", 144'(m_valid), 144'(1'b1));
      chk("done_m_r", m_r, exp_r);
      chk("done_m_src", 144'(m_src), 144'(exp_src));
      chk("done_err_timeout", 144'(err_timeout), 144'(1'b0));
      chk("done_ctrl_ready", 144'(ctrl_ready), 144'(1'b0));
      chk("done_cal_ready", 144'(cal_ready), 144'(1'b0));
      step();
      chk("post_m_valid", 144'(m_valid), 144'(1'b0));
      chk("post_err_timeout", 144'(err_timeout), 144'(1'b0));
    end
  endtask

  initial begin
    reset = 1'b0;
    ctrl_valid = 1'b0; cal_valid = 1'b0;
    ctrl_rx = '0; ctrl_ry = '0; cal_rx = '0; cal_ry = '0;
    rm_valid_out = 1'b0; rm_r = '0;
    m_last = 1'b1; exp_r = '0; exp_src = 1'b0;

    // Reset state
    step(); step();
    chk("rst_m_r", m_r, 144'(0));
    chk("rst_m_src", 144'(m_src), 144'(1'b0));
    chk("rst_rm_rx", 144'(rm_rx), 144'(0));
    chk("rst_rm_ry", 144'(rm_ry), 144'(0));
    chk("rst_rm_valid_in", 144'(rm_valid_in), 144'(1'b0));
    chk("rst_err_timeout", 144'(err_timeout), 144'(1'b0));
    chk_idle_strobes("rst");
    reset = 1'b1;
    step();

    // Single ctrl request, datapath answers 3 cycles after start
    run_txn(1'b1, 1'b0, 13'h1F56, 13'h00AA, 13'h0, 13'h0, 2, 1'b0);

    // Cal request with both angles clamped
    run_txn(1'b0, 1'b1, 13'h0, 13'h0, 13'd300, 13'h1ED4, 1, 1'b0);

    // Both sources held valid: round-robin ctrl, cal, ctrl, cal
    for (int t = 0; t < 4; t++)
      run_txn(1'b1, 1'b1, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom),
              int'($urandom_range(0, 4)), 1'b1);
    ctrl_valid = 1'b0; cal_valid = 1'b0;

    // Watchdog abort, then a normal request
    run_txn(1'b1, 1'b0, 13'd100, 13'h1F9C, 13'h0, 13'h0, -1, 1'b0);
    run_txn(1'b0, 1'b1, 13'h0, 13'h0, 13'd77, 13'd5, 0, 1'b0);

    // Result on the final WAIT cycle: capture wins
    run_txn(1'b1, 1'b0, 13'd20, 13'd30, 13'h0, 13'h0, TIMEOUT - 1, 1'b0);

    // Reset during WAIT, then a stale result
    ctrl_valid = 1'b1; ctrl_rx = 13'd40; ctrl_ry = 13'd50;
    step();
    ctrl_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_last = 1'b1; exp_r = '0; exp_src = 1'b0;
    chk("mrst_m_r", m_r, 144'(0));
    chk("mrst_m_src", 144'(m_src), 144'(1'b0));
    chk("mrst_rm_rx", 144'(rm_rx), 144'(0));
    chk("mrst_rm_ry", 144'(rm_ry), 144'(0));
    chk("mrst_rm_valid_in", 144'(rm_valid_in), 144'(1'b0));
    chk_idle_strobes("mrst");
    rm_valid_out = 1'b1; rm_r = rand_mat();
    step();
    rm_valid_out = 1'b0;
    chk("stale_m_valid", 144'(m_valid), 144'(1'b0));
    chk("stale_m_r", m_r, 144'(0));
    step();
    chk("stale_m_valid2", 144'(m_valid), 144'(1'b0));
    chk("stale_err_timeout", 144'(err_timeout), 144'(1'b0));
    run_txn(1'b1, 1'b1, 13'd1, 13'd2, 13'd3, 13'd4, 1, 1'b0);

    // Randomized requests
    for (int t = 0; t < 12; t++) begin
      bit cv, kv;
      cv = 1'($urandom);
      kv = 1'($urandom);
      if (!cv && !kv) kv = 1'b1;
      run_txn(cv, kv, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom));
      ctrl_valid = 1'b0; cal_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
